// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants, opcodes and EX/MEM state encoding
package pipeline_pkg;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_BEQ = 3'b001;
  localparam logic [OPW-1:0] OP_CMP = 3'b011;
  localparam logic [OPW-1:0] OP_AND = 3'b100;
  localparam logic [OPW-1:0] OP_OR  = 3'b101;
  localparam logic [OPW-1:0] OP_XOR = 3'b110;
  localparam logic [OPW-1:0] OP_NOT = 3'b111;

  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;

  // Encoding doubles as the entry count
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] occ_of(skid_state_e s);
    return logic'(s == ST_FULL) ? 2'd2 : (s == ST_ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// rtl/ex_mem_skid_stage_if.sv - EX->MEM handshake bundle with producer/consumer views
interface ex_mem_skid_stage_if #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 3
);
  logic           ex_valid;
  logic           ex_ready;
  logic [DW-1:0]  ex_result;
  logic [OPW-1:0] ex_op;
  logic [DW-1:0]  ex_store_data;
  logic [RW-1:0]  ex_rd;
  logic [3:0]     ex_ctrl;

  logic           mem_valid;
  logic           mem_ready;
  logic [DW-1:0]  mem_result;
  logic [DW-1:0]  mem_store_data;
  logic [RW-1:0]  mem_rd;
  logic [3:0]     mem_ctrl;

  // Environment side: drives EXECUTE outputs and MEMORY ready
  modport master (
    output ex_valid, ex_result, ex_op, ex_store_data, ex_rd, ex_ctrl, mem_ready,
    input  ex_ready, mem_valid, mem_result, mem_store_data, mem_rd, mem_ctrl
  );

  // Stage side
  modport slave (
    input  ex_valid, ex_result, ex_op, ex_store_data, ex_rd, ex_ctrl, mem_ready,
    output ex_ready, mem_valid, mem_result, mem_store_data, mem_rd, mem_ctrl
  );
endinterface

// File: rtl/ex_mem_entry_reg.sv
// rtl/ex_mem_entry_reg.sv - loadable register holding one pipeline entry
module ex_mem_entry_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] result_i,
  input  logic [DW-1:0] store_data_i,
  input  logic [RW-1:0] rd_i,
  input  logic [3:0]    ctrl_i,
  output logic [DW-1:0] result_o,
  output logic [DW-1:0] store_data_o,
  output logic [RW-1:0] rd_o,
  output logic [3:0]    ctrl_o
);
  logic [DW-1:0] result_q;
  logic [DW-1:0] store_data_q;
  logic [RW-1:0] rd_q;
  logic [3:0]    ctrl_q;

  // Capture the whole entry when loaded, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q     <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
    end else if (load_i) begin
      result_q     <= result_i;
      store_data_q <= store_data_i;
      rd_q         <= rd_i;
      ctrl_q       <= ctrl_i;
    end
  end

  assign result_o     = result_q;
  assign store_data_o = store_data_q;
  assign rd_o         = rd_q;
  assign ctrl_o       = ctrl_q;
endmodule

// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - EX/MEM boundary with 2-entry skid buffer and branch resolve
module ex_mem_skid_stage
  import pipeline_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 3
) (
  input  logic                clk,
  input  logic                rst,
  ex_mem_skid_stage_if.slave  bus,
  input  logic                flush,
  output logic                branch_taken,
  output logic [1:0]          occupancy
);
  skid_state_e state_q, state_d;
  logic        ex_ready_q;
  logic        mem_valid_q;
  logic [1:0]  occupancy_q;
  logic        branch_q, branch_d;

  logic push, pop;
  logic head_load, skid_load;

  logic [DW-1:0] head_result_d, head_store_d;
  logic [RW-1:0] head_rd_d;
  logic [3:0]    head_ctrl_d;

  logic [DW-1:0] skid_result, skid_store;
  logic [RW-1:0] skid_rd;
  logic [3:0]    skid_ctrl;

  assign push = bus.ex_valid & ex_ready_q;
  assign pop  = mem_valid_q & bus.mem_ready;

  // Next state, entry load enables and branch resolution; flush overrides everything
  always_comb begin
    state_d   = state_q;
    head_load = 1'b0;
    skid_load = 1'b0;
    branch_d  = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      branch_d = push && (bus.ex_op == OP_BEQ) && (bus.ex_result == DW'(1));
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d   = ST_ONE;
            head_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d   = ST_ONE;
            head_load = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // In FULL the head refills from the skid entry, otherwise from EXECUTE
  always_comb begin
    head_result_d = bus.ex_result;
    head_store_d  = bus.ex_store_data;
    head_rd_d     = bus.ex_rd;
    head_ctrl_d   = bus.ex_ctrl;
    if (state_q == ST_FULL) begin
      head_result_d = skid_result;
      head_store_d  = skid_store;
      head_rd_d     = skid_rd;
      head_ctrl_d   = skid_ctrl;
    end
  end

  // FSM state plus registered handshake, occupancy and branch outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      ex_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
      branch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ex_ready_q  <= (state_d != ST_FULL);
      mem_valid_q <= (state_d != ST_EMPTY);
      occupancy_q <= occ_of(state_d);
      branch_q    <= branch_d;
    end
  end

  ex_mem_entry_reg #(.DW(DW), .RW(RW)) u_head (
    .clk          (clk),
    .rst          (rst),
    .load_i       (head_load),
    .result_i     (head_result_d),
    .store_data_i (head_store_d),
    .rd_i         (head_rd_d),
    .ctrl_i       (head_ctrl_d),
    .result_o     (bus.mem_result),
    .store_data_o (bus.mem_store_data),
    .rd_o         (bus.mem_rd),
    .ctrl_o       (bus.mem_ctrl)
  );

  ex_mem_entry_reg #(.DW(DW), .RW(RW)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .load_i       (skid_load),
    .result_i     (bus.ex_result),
    .store_data_i (bus.ex_store_data),
    .rd_i         (bus.ex_rd),
    .ctrl_i       (bus.ex_ctrl),
    .result_o     (skid_result),
    .store_data_o (skid_store),
    .rd_o         (skid_rd),
    .ctrl_o       (skid_ctrl)
  );

  assign bus.ex_ready  = ex_ready_q;
  assign bus.mem_valid = mem_valid_q;
  assign branch_taken  = branch_q;
  assign occupancy     = occupancy_q;
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb/tb_ex_mem_skid_stage.sv - directed self-checking bench for ex_mem_skid_stage
module tb_ex_mem_skid_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       branch_taken;
  logic [1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_skid_stage_if bus();

  ex_mem_skid_stage dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .flush        (flush),
    .branch_taken (branch_taken),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [2:0] op,
                       input logic [31:0] sd, input logic [4:0] rd, input logic [3:0] ctrl);
    bus.ex_valid      = v;
    bus.ex_result     = res;
    bus.ex_op         = op;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    bus.ex_ctrl       = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.mem_ready = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 32'h0, 5'd0, 4'h0);
    #3;
    check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_ex_ready", 64'(bus.ex_ready), 64'd1);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_branch", 64'(branch_taken), 64'd0);
    check("rst_mem_result", 64'(bus.mem_result), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Streaming at full rate
    bus.mem_ready = 1'b1;
    drive(1'b1, 32'h10, 3'b000, 32'h0, 5'd1, 4'b1000);
    tick();
    check("stream_res0", 64'(bus.mem_result), 64'h10);
    check("stream_occ0", 64'(occupancy), 64'd1);
    drive(1'b1, 32'h20, 3'b000, 32'h0, 5'd2, 4'b1000);
    tick();
    check("stream_res1", 64'(bus.mem_result), 64'h20);
    check("stream_occ1", 64'(occupancy), 64'd1);
    drive(1'b1, 32'h30, 3'b000, 32'h0, 5'd3, 4'b1000);
    tick();
    check("stream_res2", 64'(bus.mem_result), 64'h30);
    check("stream_rd2", 64'(bus.mem_rd), 64'd3);
    check("stream_ready", 64'(bus.ex_ready), 64'd1);
    drive(1'b0, 32'h0, 3'b000, 32'h0, 5'd0, 4'h0);
    tick();
    check("stream_drain_occ", 64'(occupancy), 64'd0);
    check("stream_drain_valid", 64'(bus.mem_valid), 64'd0);

    // Stall fills the skid; head holds
    bus.mem_ready = 1'b0;
    drive(1'b1, 32'hAAAA0001, 3'b000, 32'h1111, 5'd4, 4'b0010);
    tick();
    check("stall_occ1", 64'(occupancy), 64'd1);
    drive(1'b1, 32'hBBBB0002, 3'b000, 32'h2222, 5'd5, 4'b0100);
    tick();
    check("stall_occ2", 64'(occupancy), 64'd2);
    check("stall_ex_ready", 64'(bus.ex_ready), 64'd0);
    check("stall_head", 64'(bus.mem_result), 64'hAAAA0001);
    drive(1'b1, 32'hCCCC0003, 3'b000, 32'h3333, 5'd6, 4'b1111);
    tick();
    check("stall_hold_res", 64'(bus.mem_result), 64'hAAAA0001);
    check("stall_hold_sd", 64'(bus.mem_store_data), 64'h1111);
    check("stall_hold_rd", 64'(bus.mem_rd), 64'd4);
    check("stall_hold_ctrl", 64'(bus.mem_ctrl), 64'b0010);
    check("stall_hold_occ", 64'(occupancy), 64'd2);
    drive(1'b0, 32'h0, 3'b000, 32'h0, 5'd0, 4'h0);
    bus.mem_ready = 1'b1;
    tick();
    check("unstall_res", 64'(bus.mem_result), 64'hBBBB0002);
    check("unstall_sd", 64'(bus.mem_store_data), 64'h2222);
    check("unstall_occ", 64'(occupancy), 64'd1);
    check("unstall_ready", 64'(bus.ex_ready), 64'd1);
    tick();
    check("unstall_drain", 64'(occupancy), 64'd0);

    // Branch resolution
    drive(1'b1, 32'h1, 3'b001, 32'h0, 5'd0, 4'h0);
    tick();
    check("beq_taken", 64'(branch_taken), 64'd1);
    drive(1'b0, 32'h0, 3'b000, 32'h0, 5'd0, 4'h0);
    tick();
    check("beq_pulse_end", 64'(branch_taken), 64'd0);
    drive(1'b1, 32'h0, 3'b001, 32'h0, 5'd0, 4'h0);
    tick();
    check("beq_res0", 64'(branch_taken), 64'd0);
    drive(1'b1, 32'h3, 3'b001, 32'h0, 5'd0, 4'h0);
    tick();
    check("beq_res3", 64'(branch_taken), 64'd0);
    drive(1'b1, 32'h1, 3'b000, 32'h0, 5'd0, 4'h0);
    tick();
    check("add_res1", 64'(branch_taken), 64'd0);
    drive(1'b0, 32'h0, 3'b000, 32'h0, 5'd0, 4'h0);
    tick();

    // Branch entry landing in skid must not pulse again when promoted
    bus.mem_ready = 1'b0;
    drive(1'b1, 32'h77, 3'b000, 32'h0, 5'd7, 4'h0);
    tick();
    drive(1'b1, 32'h1, 3'b001, 32'h0, 5'd8, 4'h0);
    tick();
    check("skid_beq_taken", 64'(branch_taken), 64'd1);
    drive(1'b0, 32'h0, 3'b000, 32'h0, 5'd0, 4'h0);
    tick();
    check("skid_beq_end", 64'(branch_taken), 64'd0);
    bus.mem_ready = 1'b1;
    tick();
    check("promote_res", 64'(bus.mem_result), 64'h1);
    check("promote_rd", 64'(bus.mem_rd), 64'd8);
    check("promote_no_branch", 64'(branch_taken), 64'd0);
    tick();

    // Flush beats push and pop
    bus.mem_ready = 1'b0;
    drive(1'b1, 32'h100, 3'b000, 32'h0, 5'd9, 4'h0);
    tick();
    drive(1'b1, 32'h200, 3'b000, 32'h0, 5'd10, 4'h0);
    tick();
    check("pre_flush_occ", 64'(occupancy), 64'd2);
    flush         = 1'b1;
    bus.mem_ready = 1'b1;
    drive(1'b1, 32'h1, 3'b001, 32'h0, 5'd11, 4'h0);
    tick();
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_valid", 64'(bus.mem_valid), 64'd0);
    check("flush_ready", 64'(bus.ex_ready), 64'd1);
    check("flush_branch", 64'(branch_taken), 64'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 32'h0, 5'd0, 4'h0);
    tick();
    check("flush_lost", 64'(bus.mem_valid), 64'd0);

    // Simultaneous push and pop in ONE
    bus.mem_ready = 1'b0;
    drive(1'b1, 32'h5, 3'b000, 32'h55, 5'd5, 4'b1000);
    tick();
    check("pp_head5", 64'(bus.mem_result), 64'h5);
    bus.mem_ready = 1'b1;
    drive(1'b1, 32'h6, 3'b000, 32'hDEAD, 5'd6, 4'b0010);
    tick();
    check("pp_occ", 64'(occupancy), 64'd1);
    check("pp_res", 64'(bus.mem_result), 64'h6);
    check("pp_rd", 64'(bus.mem_rd), 64'd6);
    check("pp_ctrl", 64'(bus.mem_ctrl), 64'b0010);
    check("pp_sd", 64'(bus.mem_store_data), 64'hDEAD);

    // Asynchronous reset mid-cycle while FULL
    bus.mem_ready = 1'b0;
    drive(1'b1, 32'h9, 3'b000, 32'h0, 5'd1, 4'h0);
    tick();
    drive(1'b0, 32'h0, 3'b000, 32'h0, 5'd0, 4'h0);
    check("pre_rst_occ", 64'(occupancy), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.mem_valid), 64'd0);
    check("arst_ready", 64'(bus.ex_ready), 64'd1);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_branch", 64'(branch_taken), 64'd0);
    #2;
    rst = 1'b0;
    tick();
    check("post_rst_occ", 64'(occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
